// File: rtl/fifo_uart_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_pkg
// Shared definitions for the FIFO-draining UART transmitter.
//   state_t          : transmitter FSM states
//   UART_START_BIT   : line level of the start bit
//   UART_STOP_BIT    : line level of the stop bit (also the idle level)
//   UART_DATA_BITS   : data bits per frame
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
// -----------------------------------------------------------------------------
package fifo_uart_pkg;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;
    localparam int   UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_LOAD,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

endpackage : fifo_uart_pkg

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
// Bit-time counter. Counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_done
// for one cycle on the last count of each bit-time, then wraps to 0.
//   ck       : clock, posedge
//   rst      : synchronous reset, active low
//   clear    : forces the count back to 0 (has priority over en)
//   en       : count enable
//   bit_done : high during the final cycle of a bit-time
// -----------------------------------------------------------------------------
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic ck,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic bit_done
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge ck) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    assign bit_done = en && !clear && (cnt_reg == CNT_LAST);

endmodule : uart_baud_cnt

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Pops bytes from a 16-entry byte FIFO (registered read data) and sends each
// one as an 8N1 UART frame, LSB first. One read strobe per frame; a new frame
// always passes through IDLE, REQ and LOAD, so there is no prefetch.
//   ck      : clock, posedge
//   rst     : synchronous reset, active low
//   txen    : transmit enable; gates only the start of a new frame
//   Fempty  : FIFO empty flag
//   Dout    : FIFO read data, valid the cycle after the read edge
//   Ren     : FIFO read strobe, one cycle per byte
//   txd     : serial output, idles high
//   busy    : high whenever the FSM is outside IDLE
// Optional feature macro: UART_TX_PARITY_EN appends an even-parity bit
// (11 bit-times per frame instead of 10).
// -----------------------------------------------------------------------------
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       txen,
    input  logic       Fempty,
    input  logic [7:0] Dout,
    output logic       Ren,
    output logic       txd,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    state_t                    state_reg;
    logic [UART_DATA_BITS-1:0] shreg_reg;
    logic [2:0]                bit_idx_reg;
    logic                      txd_reg;
    logic                      ren_reg;
    logic                      busy_reg;
`ifdef UART_TX_PARITY_EN
    logic                      parity_reg;
`endif

    logic cnt_clear;
    logic cnt_en;
    logic bit_done;

    // The bit-time counter only runs while a bit is on the line; it is held
    // at 0 through the handshake so START begins with a fresh count.
    assign cnt_clear = (state_reg == ST_IDLE) || (state_reg == ST_REQ) ||
                       (state_reg == ST_LOAD);
    assign cnt_en    = !cnt_clear;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .ck      (ck),
        .rst     (rst),
        .clear   (cnt_clear),
        .en      (cnt_en),
        .bit_done(bit_done)
    );

    always_ff @(posedge ck) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            shreg_reg   <= '0;
            bit_idx_reg <= '0;
            txd_reg     <= UART_STOP_BIT;
            ren_reg     <= 1'b0;
            busy_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    txd_reg <= UART_STOP_BIT;
                    if (txen && !Fempty) begin
                        ren_reg   <= 1'b1;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_REQ;
                    end
                end

                // The FIFO pops on this edge; its data appears next cycle.
                ST_REQ: begin
                    ren_reg   <= 1'b0;
                    state_reg <= ST_LOAD;
                end

                ST_LOAD: begin
                    shreg_reg <= Dout;
`ifdef UART_TX_PARITY_EN
                    parity_reg <= ^Dout;
`endif
                    txd_reg   <= UART_START_BIT;
                    state_reg <= ST_START;
                end

                ST_START: begin
                    if (bit_done) begin
                        txd_reg     <= shreg_reg[0];
                        bit_idx_reg <= '0;
                        state_reg   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (bit_done) begin
                        if (bit_idx_reg == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            txd_reg   <= parity_reg;
                            state_reg <= ST_PARITY;
`else
                            txd_reg   <= UART_STOP_BIT;
                            state_reg <= ST_STOP;
`endif
                        end else begin
                            // Drive the next bit straight from the pre-shift
                            // value so txd changes on the same edge.
                            shreg_reg   <= shreg_reg >> 1;
                            txd_reg     <= shreg_reg[1];
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_done) begin
                        txd_reg   <= UART_STOP_BIT;
                        state_reg <= ST_STOP;
                    end
                end
`endif

                ST_STOP: begin
                    if (bit_done) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    txd_reg   <= UART_STOP_BIT;
                    ren_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign Ren  = ren_reg;
    assign txd  = txd_reg;
    assign busy = busy_reg;

endmodule : fifo_uart_tx
